// File: rtl/ram_readout_pkg.sv
// Shared types and constants for the capture-RAM readout block.
package ram_readout_pkg;

    // Readout sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int          ADDR_W_DEF    = 5;
    localparam int          DATA_W_DEF    = 64;
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

    // Frame = sync byte + address byte + data bytes.
    function automatic int frame_bytes(input int data_w);
        return 2 + data_w / 8;
    endfunction

    localparam int FRAME_BYTES = 2 + DATA_W_DEF / 8;

endpackage

// File: rtl/ram_readout_if.sv
// Bundles the start request, capture-RAM read port and byte stream of ram_readout.
interface ram_readout_if
    import ram_readout_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              start;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd_en;
    logic [DATA_W-1:0] ram_q;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;

    // The readout block itself.
    modport slave (
        input  start, first_addr, last_addr, ram_q, tx_ready,
        output ram_addr, ram_rd_en, tx_data, tx_valid, busy, done
    );

    // The surrounding system: requester, capture RAM and byte sink.
    modport master (
        output start, first_addr, last_addr, ram_q, tx_ready,
        input  ram_addr, ram_rd_en, tx_data, tx_valid, busy, done
    );

endinterface

// File: rtl/frame_ser.sv
// Serialises one frame (sync, address, data MSB first) onto a byte stream.
//
// Stream handshake: a byte transfers on a rising edge where o_tx_valid and
// i_tx_ready are both high. Once o_tx_valid rises it stays high and o_tx_data
// stays unchanged until that byte transfers; i_tx_ready may toggle freely.
module frame_ser
    import ram_readout_pkg::*;
#(
    parameter int         ADDR_W    = ADDR_W_DEF,
    parameter int         DATA_W    = DATA_W_DEF,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_word,
    input  logic              i_tx_ready,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    output logic              o_frame_done
);
    localparam int FB = frame_bytes(DATA_W);
    localparam int SW = FB * 8;

    logic [SW-1:0] r_shift;
    logic          r_valid;
    logic [3:0]    r_cnt;
    logic          w_accept;
    logic          w_last_byte;

    assign w_accept     = r_valid & i_tx_ready;
    assign w_last_byte  = (r_cnt == 4'(FB - 1));
    assign o_frame_done = w_accept & w_last_byte;
    assign o_tx_valid   = r_valid;
    assign o_tx_data    = r_shift[SW-1 -: 8];

    // Load a whole frame at once, then shift one byte out per accepted transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shift <= {SYNC_BYTE, 8'(i_addr), i_word};
            r_valid <= 1'b1;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_shift <= r_shift << 8;
            if (w_last_byte) begin
                r_valid <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_cnt   <= r_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/ram_readout.sv
// Dumps a wrapping range of capture-RAM words as framed bytes on a stream.
module ram_readout
    import ram_readout_pkg::*;
#(
    parameter int         ADDR_W    = ADDR_W_DEF,
    parameter int         DATA_W    = DATA_W_DEF,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic          clk,
    input  logic          rst,
    ram_readout_if.slave  bus,
    output state_t        o_dbg_state
);
    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [ADDR_W-1:0] r_last;
    logic [ADDR_W-1:0] w_last_nxt;
    logic              w_ser_load;
    logic              w_frame_done;

    // Next-state, address counter and frame-load decode.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_last_nxt  = r_last;
        w_ser_load  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_addr_nxt  = bus.first_addr;
                    w_last_nxt  = bus.last_addr;
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                w_state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // RAM data for the READ strobe is present now.
                w_ser_load  = 1'b1;
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (w_frame_done) begin
                    if (r_addr == r_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        // Natural wrap past the top address back to 0.
                        w_addr_nxt  = r_addr + ADDR_W'(1);
                        w_state_nxt = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, address and latched end-of-range registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_last  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign bus.ram_addr  = r_addr;
    assign bus.ram_rd_en = (r_state == ST_READ);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = (r_state == ST_DONE);
    assign o_dbg_state   = r_state;

    frame_ser #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .SYNC_BYTE (SYNC_BYTE)
    ) u_frame_ser (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_ser_load),
        .i_addr       (r_addr),
        .i_word       (bus.ram_q),
        .i_tx_ready   (bus.tx_ready),
        .o_tx_data    (bus.tx_data),
        .o_tx_valid   (bus.tx_valid),
        .o_frame_done (w_frame_done)
    );

endmodule

// File: doc/ram_readout.md
RAM_READOUT -- requirements
Module: ram_readout

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, capture-RAM address width (32 words).
REQ-002 SHALL have parameter DATA_W, default 64, capture-RAM word width; fixed multiple of 8.
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5, frame header byte.
REQ-004 clk  input  1  rising-edge clock, same domain as capture RAM read port.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle request to dump a word range.
REQ-007 first_addr  input  ADDR_W  first word to read; sampled with start.
REQ-008 last_addr  input  ADDR_W  last word to read, inclusive; sampled with start.
REQ-009 ram_addr  output  ADDR_W  read address to capture RAM.
REQ-010 ram_rd_en  output  1  read strobe; RAM returns word one cycle later.
REQ-011 ram_q  input  DATA_W  RAM read data.
REQ-012 tx_data  output  8  byte stream data.
REQ-013 tx_valid  output  1  tx_data valid.
REQ-014 tx_ready  input  1  downstream accepts byte when tx_valid and tx_ready are both high at a rising edge.
REQ-015 busy  output  1  high from the edge sampling start until the DONE state is left.
REQ-016 done  output  1  one-cycle pulse after the last byte of the last frame is accepted.

Function
REQ-017 FSM states SHALL be IDLE, READ, CAPTURE, SEND, DONE.
REQ-018 IDLE: start=1 SHALL latch first_addr and last_addr, load ram_addr=first_addr, and go to READ; start SHALL be ignored in all other states.
REQ-019 READ: ram_rd_en=1 for exactly one cycle; next state CAPTURE.
REQ-020 CAPTURE: ram_q SHALL be registered into a frame buffer; next state SEND.
REQ-021 Timing: start sampled at edge k -> ram_rd_en high in cycle k..k+1, ram_q captured at edge k+2, tx_valid high from edge k+2.
REQ-022 Frame SHALL be 2+DATA_W/8 bytes in order: SYNC_BYTE, ram_addr zero-extended to 8 bits, then data bytes MSB first.
REQ-023 tx_data SHALL be held stable while tx_valid=1 and tx_ready=0; tx_valid SHALL NOT drop until the byte is accepted.
REQ-024 With tx_ready held at 1, consecutive frame bytes SHALL be accepted on consecutive cycles with no bubble.
REQ-025 After the last frame byte is accepted: if ram_addr==last_addr go to DONE, else ram_addr increments modulo 2^ADDR_W and the FSM goes to READ.
REQ-026 Words transmitted SHALL equal ((last_addr-first_addr) mod 2^ADDR_W)+1; first_addr==last_addr yields one frame; last_addr<first_addr wraps through the top address to 0.
REQ-027 DONE: done=1 for one cycle, busy stays 1; next state IDLE.
REQ-028 ram_rd_en SHALL be 0 in every state except READ.

Reset
REQ-029 rst=1 at any edge SHALL force IDLE, tx_valid=0, ram_rd_en=0, busy=0, done=0, ram_addr=0, tx_data=0, latched range=0, including mid-frame; a partly sent frame is abandoned.
REQ-030 rst SHALL take priority over start in the same cycle.

Structure
REQ-031 A shared package SHALL hold the state enumeration, SYNC_BYTE default, and FRAME_BYTES = 2+DATA_W/8.
REQ-032 Byte sequencing SHALL live in one sub-module frame_ser, which loads the address and data word and drives the tx_data/tx_valid/tx_ready handshake with a 4-bit byte counter; the top level holds the FSM and address counter.

Verification
REQ-033 first=3, last=3, RAM[3]=64'h0123456789ABCDEF, tx_ready=1 -> bytes A5 03 01 23 45 67 89 AB CD EF on 10 consecutive cycles, then done pulse, busy low.
REQ-034 first=30, last=1 -> 4 frames with address bytes 1E 1F 00 01 in order; ram_rd_en pulses exactly 4 times.
REQ-035 tx_ready toggled pseudo-randomly (about 50%) over a 3-word range -> tx_data never changes while tx_valid=1 and tx_ready=0; byte sequence identical to the tx_ready=1 run.
REQ-036 start re-asserted while busy with first=0, last=31 -> ignored; original range completes unchanged.
REQ-037 rst asserted during byte 5 of frame 2 -> next cycle tx_valid=0, busy=0; a fresh start then sends a complete frame beginning with A5.
